// File: rtl/layer_compositor.sv
// layer_compositor
//   Merges NUM_LAYERS sprite layers over a background with fixed priority
//   (layer 0 highest), owns the START/PLAY/END screen-mode FSM, blinks the
//   player layer (layer 0) after a hit and drives a registered pixel.
//
// Optional build macro: COLOR_KEY_EN
//   Defined   - a layer whose colour equals KEY_COLOR counts as uncovered.
//   Undefined - layer_en alone decides coverage (no key comparators).
//
// Ports:
//   clk            pixel clock
//   rst            synchronous active-high reset
//   frame_start    one-cycle pulse at pixel (0,0)
//   layer_en       per-layer coverage flags
//   layer_rgb      packed layer colours, layer i = [i*RGB_W +: RGB_W]
//   background_rgb background pixel used in PLAY
//   start_rgb      start-screen pixel
//   end_rgb        game-over pixel
//   start_req      start / restart request (level or pulse)
//   player_dead    player health reached zero
//   hit_pulse      one-cycle pulse, player took damage
//   rgb_out        composited pixel, two clocks after the inputs
//   mode           current screen: 0 START, 1 PLAY, 2 END
//   flashing       high while the flash counter is non-zero

module layer_compositor #(
    parameter int unsigned      NUM_LAYERS   = 8,
    parameter int unsigned      RGB_W        = 12,
    parameter logic [RGB_W-1:0] KEY_COLOR    = '0,
    parameter logic [5:0]       FLASH_FRAMES = 6'd32,
    parameter int unsigned      BLINK_BIT    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_start,
    input  logic [NUM_LAYERS-1:0]       layer_en,
    input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [RGB_W-1:0]            background_rgb,
    input  logic [RGB_W-1:0]            start_rgb,
    input  logic [RGB_W-1:0]            end_rgb,
    input  logic                        start_req,
    input  logic                        player_dead,
    input  logic                        hit_pulse,
    output logic [RGB_W-1:0]            rgb_out,
    output logic [1:0]                  mode,
    output logic                        flashing
);

    typedef enum logic [1:0] {
        MODE_START = 2'd0,
        MODE_PLAY  = 2'd1,
        MODE_END   = 2'd2
    } mode_e;

    mode_e            state_q, state_d;
    logic             pend_q, pend_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             flashing_q;

    // Stage 1 registers
    logic             hit_valid_q;
    logic [RGB_W-1:0] sel_rgb_q;
    mode_e            s1_mode_q;
    logic [RGB_W-1:0] s1_bg_q, s1_start_q, s1_end_q;

    // Stage 2 register
    logic [RGB_W-1:0] rgb_q, rgb_d;

    logic [NUM_LAYERS-1:0] eff_en;
    logic                  hit_valid_d;
    logic [RGB_W-1:0]      sel_rgb_d;

    // Mode FSM: a request may arrive any time; it is held in pend until the
    // next frame_start, and a request coinciding with frame_start acts at once.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            MODE_START: begin
                if (start_req) pend_d = 1'b1;
                if (frame_start && pend_d) begin
                    state_d = MODE_PLAY;
                    pend_d  = 1'b0;
                end
            end
            MODE_PLAY: begin
                if (player_dead) pend_d = 1'b1;
                if (frame_start && pend_d) begin
                    state_d = MODE_END;
                    pend_d  = 1'b0;
                end
            end
            MODE_END: begin
                if (start_req) pend_d = 1'b1;
                if (frame_start && pend_d) begin
                    state_d = MODE_START;
                    pend_d  = 1'b0;
                end
            end
            default: begin
                state_d = MODE_START;
                pend_d  = 1'b0;
            end
        endcase
    end

    // Flash counter: mode change clears, hit reload beats the frame decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (hit_pulse && state_q == MODE_PLAY) begin
            cnt_d = FLASH_FRAMES;
        end else if (frame_start && cnt_q != '0) begin
            cnt_d = cnt_q - 6'd1;
        end
    end

    // Effective coverage; layer 0 is blanked during the "off" half of the blink.
    always_comb begin
        eff_en = layer_en;
`ifdef COLOR_KEY_EN
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (layer_rgb[i*RGB_W +: RGB_W] == KEY_COLOR) eff_en[i] = 1'b0;
        end
`endif
        if (flashing_q && cnt_q[BLINK_BIT]) eff_en[0] = 1'b0;
    end

    // Priority encoder: first (lowest-index) covered layer wins.
    always_comb begin
        hit_valid_d = 1'b0;
        sel_rgb_d   = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (eff_en[i] && !hit_valid_d) begin
                hit_valid_d = 1'b1;
                sel_rgb_d   = layer_rgb[i*RGB_W +: RGB_W];
            end
        end
    end

    always_comb begin
        rgb_d = '0;
        case (s1_mode_q)
            MODE_START: rgb_d = s1_start_q;
            MODE_END:   rgb_d = s1_end_q;
            MODE_PLAY:  rgb_d = hit_valid_q ? sel_rgb_q : s1_bg_q;
            default:    rgb_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MODE_START;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            flashing_q  <= 1'b0;
            hit_valid_q <= 1'b0;
            sel_rgb_q   <= '0;
            s1_mode_q   <= MODE_START;
            s1_bg_q     <= '0;
            s1_start_q  <= '0;
            s1_end_q    <= '0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            flashing_q  <= (cnt_d != '0);
            hit_valid_q <= hit_valid_d;
            sel_rgb_q   <= sel_rgb_d;
            // Next mode, so the first pixel of a new frame uses the new screen.
            s1_mode_q   <= state_d;
            s1_bg_q     <= background_rgb;
            s1_start_q  <= start_rgb;
            s1_end_q    <= end_rgb;
            rgb_q       <= rgb_d;
        end
    end

    assign rgb_out  = rgb_q;
    assign mode     = state_q;
    assign flashing = flashing_q;

endmodule
